// File: rtl/stopwatch_bcd_counter_if.sv
// stopwatch_bcd_counter_if: timer tick, button pulses and display/status bundle for the stopwatch
interface stopwatch_bcd_counter_if;
  logic       i_base_tick;
  logic       i_start_stop;
  logic       i_clear;
  logic       i_lap;
  logic       o_timerenb;
  logic       o_lap_active;
  logic       o_overflow;
  logic [3:0] o_hund_ones;
  logic [3:0] o_hund_tens;
  logic [3:0] o_sec_ones;
  logic [3:0] o_sec_tens;
  logic [3:0] o_min_ones;
  logic [3:0] o_min_tens;
  modport master (
    output i_base_tick, i_start_stop, i_clear, i_lap,
    input  o_timerenb, o_lap_active, o_overflow,
    input  o_hund_ones, o_hund_tens, o_sec_ones, o_sec_tens, o_min_ones, o_min_tens
  );
  modport slave (
    input  i_base_tick, i_start_stop, i_clear, i_lap,
    output o_timerenb, o_lap_active, o_overflow,
    output o_hund_ones, o_hund_tens, o_sec_ones, o_sec_tens, o_min_ones, o_min_tens
  );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: MM:SS.hh BCD stopwatch with start/stop/clear/lap control
module stopwatch_bcd_counter #(
  parameter int MIN_WRAP = 60
) (
  input logic i_sclk,
  input logic i_reset_n,
  stopwatch_bcd_counter_if.slave sw
);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;
  localparam logic [3:0] WRAP_TENS = 4'((MIN_WRAP - 1) / 10);
  localparam logic [3:0] WRAP_ONES = 4'((MIN_WRAP - 1) % 10);
  localparam logic [5:0][3:0] DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  state_t state, state_n;
  logic tick_d, run_tick, wrap, wrap_q, lap_on, lap_flip, lap_grab;
  logic [5:0][3:0] live, live_n, lap, disp;
  assign run_tick = sw.i_base_tick & ~tick_d & (state == RUNNING);
  assign wrap = (live[3:0] == 16'h5999) && (live[4] == WRAP_ONES) && (live[5] == WRAP_TENS);
  // lap toggles while held, but only a running stopwatch may take a new snapshot
  assign lap_flip = sw.i_lap & (lap_on | (state == RUNNING));
  assign lap_grab = lap_flip & ~lap_on & ~sw.i_clear;
  assign sw.o_hund_ones = disp[0];
  assign sw.o_hund_tens = disp[1];
  assign sw.o_sec_ones = disp[2];
  assign sw.o_sec_tens = disp[3];
  assign sw.o_min_ones = disp[4];
  assign sw.o_min_tens = disp[5];
  always_comb begin
    state_n = sw.i_clear ? IDLE : sw.i_start_stop ? ((state == RUNNING) ? PAUSED : RUNNING) : state;
  end
  always_comb begin
    logic carry;
    carry = 1'b1;
    live_n = live;
    for (int i = 0; i < 6; i++) begin
      live_n[i] = carry ? ((live[i] == DIGIT_MAX[i]) ? 4'd0 : live[i] + 4'd1) : live[i];
      carry = carry & (live[i] == DIGIT_MAX[i]);
    end
  end
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      tick_d <= 1'b0;
      live <= '0;
      lap <= '0;
      disp <= '0;
      wrap_q <= 1'b0;
      lap_on <= 1'b0;
      sw.o_lap_active <= 1'b0;
      sw.o_overflow <= 1'b0;
      sw.o_timerenb <= 1'b0;
    end else begin
      state <= state_n;
      tick_d <= sw.i_base_tick;
      live <= sw.i_clear ? '0 : !run_tick ? live : wrap ? '0 : live_n;
      wrap_q <= ~sw.i_clear & run_tick & wrap;
      lap_on <= ~sw.i_clear & (lap_on ^ lap_flip);
      if (lap_grab) lap <= live;
      disp <= lap_on ? lap : live;
      sw.o_lap_active <= lap_on;
      sw.o_overflow <= wrap_q;
      sw.o_timerenb <= (state_n == RUNNING);
    end
  end
endmodule
